// File: rtl/adder4_sched_if.sv
// Bus bundle for adder4_sched: two requester ports, the response port and the
// shared 4-bit adder datapath. Optional rsp_ovf exists only when
// ADDER4_SCHED_OVF_EN is defined.
interface adder4_sched_if #(
  parameter int unsigned NIBBLES = 4
);
  localparam int unsigned W = 4 * NIBBLES;

  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_cin;

  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req1_cin;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout;
  logic         rsp_id;
`ifdef ADDER4_SCHED_OVF_EN
  logic         rsp_ovf;
`endif

  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_sum;
  logic         add_cout;

  // Scheduler side
  modport slave (
`ifdef ADDER4_SCHED_OVF_EN
    output rsp_ovf,
`endif
    input  req0_valid, req0_a, req0_b, req0_cin,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_cin,
    output req1_ready,
    output rsp_valid, rsp_sum, rsp_cout, rsp_id,
    input  rsp_ready,
    output add_a, add_b, add_cin,
    input  add_sum, add_cout
  );

  // Requester / consumer / adder side
  modport master (
`ifdef ADDER4_SCHED_OVF_EN
    input  rsp_ovf,
`endif
    output req0_valid, req0_a, req0_b, req0_cin,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_cin,
    input  req1_ready,
    input  rsp_valid, rsp_sum, rsp_cout, rsp_id,
    output rsp_ready,
    input  add_a, add_b, add_cin,
    output add_sum, add_cout
  );
endinterface

// File: rtl/adder4_sched.sv
// adder4_sched: round-robin arbiter and nibble-serial sequencer sharing one
// external 4-bit adder between two requesters. One operation in flight.
// Define ADDER4_SCHED_OVF_EN to add rsp_ovf (signed overflow of the top nibble).
module adder4_sched #(
  parameter int unsigned NIBBLES = 4
) (
  input logic           clk,
  input logic           rst,
  adder4_sched_if.slave bus
);
  localparam int unsigned IdxW = $clog2(NIBBLES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                  state_q, state_d;
  logic                    last_q, last_d;   // 1: req1 granted last, req0 wins a tie
  logic                    id_q, id_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic                    carry_q, carry_d;
  logic                    cout_q, cout_d;
  logic [NIBBLES-1:0][3:0] a_q, a_d;
  logic [NIBBLES-1:0][3:0] b_q, b_d;
  logic [NIBBLES-1:0][3:0] sum_q, sum_d;
`ifdef ADDER4_SCHED_OVF_EN
  logic                    ovf_q, ovf_d;
`endif

  logic grant0, grant1, accept;

  // Round-robin arbitration and handshake/datapath outputs
  always_comb begin
    grant0 = bus.req0_valid & (~bus.req1_valid | last_q);
    grant1 = bus.req1_valid & (~bus.req0_valid | ~last_q);

    bus.req0_ready = (state_q == StIdle) & ~rst & grant0;
    bus.req1_ready = (state_q == StIdle) & ~rst & grant1;
    accept         = bus.req0_ready | bus.req1_ready;

    bus.add_a   = 4'h0;
    bus.add_b   = 4'h0;
    bus.add_cin = 1'b0;
    if (state_q == StRun && !rst) begin
      bus.add_a   = a_q[idx_q];
      bus.add_b   = b_q[idx_q];
      bus.add_cin = carry_q;
    end

    bus.rsp_valid = (state_q == StDone);
    bus.rsp_sum   = sum_q;
    bus.rsp_cout  = cout_q;
    bus.rsp_id    = id_q;
`ifdef ADDER4_SCHED_OVF_EN
    bus.rsp_ovf   = ovf_q;
`endif
  end

  // Next-state logic for the sequencer FSM and its datapath registers
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
`ifdef ADDER4_SCHED_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          a_d     = grant0 ? bus.req0_a   : bus.req1_a;
          b_d     = grant0 ? bus.req0_b   : bus.req1_b;
          carry_d = grant0 ? bus.req0_cin : bus.req1_cin;
          id_d    = ~grant0;
          last_d  = ~grant0;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[idx_q] = bus.add_sum;
        carry_d      = bus.add_cout;
        if (idx_q == LastIdx) begin
          cout_d  = bus.add_cout;
`ifdef ADDER4_SCHED_OVF_EN
          // carry into bit 3 xor carry out of bit 3
          ovf_d   = bus.add_sum[3] ^ bus.add_a[3] ^ bus.add_b[3] ^ bus.add_cout;
`endif
          state_d = StDone;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StDone: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
`ifdef ADDER4_SCHED_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
`ifdef ADDER4_SCHED_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end
endmodule
